// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS pipeline datapath blocks.
package mips_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    // Encoding matches the MemtoReg control bit.
    typedef enum logic {
        WbSrcAlu = 1'b0,
        WbSrcMem = 1'b1
    } wb_src_e;

endpackage

// File: rtl/regfile_core.sv
// Register array with hard-wired zero register and same-cycle write-to-read bypass.
module regfile_core #(
    parameter int unsigned DATA_W     = mips_pkg::DATA_W,
    parameter int unsigned REG_ADDR_W = mips_pkg::REG_ADDR_W,
    parameter int unsigned NUM_REGS   = mips_pkg::NUM_REGS
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  we_i,
    input  logic [REG_ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [REG_ADDR_W-1:0] raddr1_i,
    input  logic [REG_ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0]     rdata1_o,
    output logic [DATA_W-1:0]     rdata2_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              wr_en;
    logic              bypass1;
    logic              bypass2;

    assign wr_en = we_i && (waddr_i != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign bypass1 = wr_en && (raddr1_i == waddr_i);
    assign bypass2 = wr_en && (raddr2_i == waddr_i);

    // Index 0 wins over both the array and the bypass path.
    always_comb begin
        rdata1_o = '0;
        rdata2_o = '0;
        if (raddr1_i != '0) begin
            rdata1_o = bypass1 ? wdata_i : regs_q[raddr1_i];
        end
        if (raddr2_i != '0) begin
            rdata2_o = bypass2 ? wdata_i : regs_q[raddr2_i];
        end
    end

endmodule

// File: rtl/writeback_regfile.sv
// MEM/WB pipeline latch with MemtoReg select, feeding the register file write port.
module writeback_regfile #(
    parameter int unsigned DATA_W     = mips_pkg::DATA_W,
    parameter int unsigned REG_ADDR_W = mips_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  stall,
    input  logic [REG_ADDR_W-1:0] mem_write_reg,
    input  logic [DATA_W-1:0]     mem_alu_result,
    input  logic [DATA_W-1:0]     mem_read_data,
    input  logic                  MemtoReg,
    input  logic                  RegWrite,
    input  logic [REG_ADDR_W-1:0] read_reg1,
    input  logic [REG_ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0]     read_data1,
    output logic [DATA_W-1:0]     read_data2,
    output logic [REG_ADDR_W-1:0] wb_write_reg,
    output logic [DATA_W-1:0]     wb_write_data,
    output logic                  wb_RegWrite
);
    import mips_pkg::wb_src_e;
    import mips_pkg::WbSrcMem;

    logic [REG_ADDR_W-1:0] wb_write_reg_q, wb_write_reg_d;
    logic [DATA_W-1:0]     wb_write_data_q, wb_write_data_d;
    logic                  wb_reg_write_q, wb_reg_write_d;
    logic [DATA_W-1:0]     mem_wb_data;
    wb_src_e               wb_src;

    assign wb_src      = wb_src_e'(MemtoReg);
    assign mem_wb_data = (wb_src == WbSrcMem) ? mem_read_data : mem_alu_result;

    always_comb begin
        wb_write_reg_d  = wb_write_reg_q;
        wb_write_data_d = wb_write_data_q;
        wb_reg_write_d  = wb_reg_write_q;
        if (!stall) begin
            wb_write_reg_d  = mem_write_reg;
            wb_write_data_d = mem_wb_data;
            wb_reg_write_d  = RegWrite;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wb_write_reg_q  <= '0;
            wb_write_data_q <= '0;
            wb_reg_write_q  <= 1'b0;
        end else begin
            wb_write_reg_q  <= wb_write_reg_d;
            wb_write_data_q <= wb_write_data_d;
            wb_reg_write_q  <= wb_reg_write_d;
        end
    end

    assign wb_write_reg  = wb_write_reg_q;
    assign wb_write_data = wb_write_data_q;
    assign wb_RegWrite   = wb_reg_write_q;

    // A held latch simply rewrites the same value each stalled cycle.
    regfile_core #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .NUM_REGS   (mips_pkg::NUM_REGS)
    ) u_regfile_core (
        .clk      (clk),
        .reset_n  (reset_n),
        .we_i     (wb_reg_write_q),
        .waddr_i  (wb_write_reg_q),
        .wdata_i  (wb_write_data_q),
        .raddr1_i (read_reg1),
        .raddr2_i (read_reg2),
        .rdata1_o (read_data1),
        .rdata2_o (read_data2)
    );

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed table-driven bench for writeback_regfile: latch, commit, bypass, stall and reset.
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic [4:0]  mem_write_reg;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_read_data;
    logic        MemtoReg;
    logic        RegWrite;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic        wb_RegWrite;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    writeback_regfile dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .stall          (stall),
        .mem_write_reg  (mem_write_reg),
        .mem_alu_result (mem_alu_result),
        .mem_read_data  (mem_read_data),
        .MemtoReg       (MemtoReg),
        .RegWrite       (RegWrite),
        .read_reg1      (read_reg1),
        .read_reg2      (read_reg2),
        .read_data1     (read_data1),
        .read_data2     (read_data2),
        .wb_write_reg   (wb_write_reg),
        .wb_write_data  (wb_write_data),
        .wb_RegWrite    (wb_RegWrite)
    );

    typedef struct {
        logic        rst_n;
        logic        stl;
        logic        rw;
        logic        m2r;
        logic [4:0]  wr;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [4:0]  rr1;
        logic [4:0]  rr2;
        logic [4:0]  e_wreg;
        logic [31:0] e_wdata;
        logic        e_we;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst_n, logic stl, logic rw, logic m2r, logic [4:0] wr,
                                logic [31:0] alu, logic [31:0] mem, logic [4:0] rr1,
                                logic [4:0] rr2, logic [4:0] e_wreg, logic [31:0] e_wdata,
                                logic e_we, logic [31:0] e_rd1, logic [31:0] e_rd2);
        vec_t v;
        v.rst_n = rst_n;  v.stl = stl;  v.rw = rw;  v.m2r = m2r;  v.wr = wr;
        v.alu = alu;  v.mem = mem;  v.rr1 = rr1;  v.rr2 = rr2;
        v.e_wreg = e_wreg;  v.e_wdata = e_wdata;  v.e_we = e_we;
        v.e_rd1 = e_rd1;  v.e_rd2 = e_rd2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic apply(input int idx, input vec_t v);
        string tag;
        @(negedge clk);
        reset_n        = v.rst_n;
        stall          = v.stl;
        RegWrite       = v.rw;
        MemtoReg       = v.m2r;
        mem_write_reg  = v.wr;
        mem_alu_result = v.alu;
        mem_read_data  = v.mem;
        read_reg1      = v.rr1;
        read_reg2      = v.rr2;
        @(posedge clk);
        #1;
        tag = $sformatf("vec%0d", idx);
        chk({tag, ".wb_write_reg"},  32'(wb_write_reg), 32'(v.e_wreg));
        chk({tag, ".wb_write_data"}, wb_write_data,     v.e_wdata);
        chk({tag, ".wb_RegWrite"},   32'(wb_RegWrite),  32'(v.e_we));
        chk({tag, ".read_data1"},    read_data1,        v.e_rd1);
        chk({tag, ".read_data2"},    read_data2,        v.e_rd2);
    endtask

    initial begin
        reset_n = 1'b0;  stall = 1'b0;  RegWrite = 1'b0;  MemtoReg = 1'b0;
        mem_write_reg = '0;  mem_alu_result = '0;  mem_read_data = '0;
        read_reg1 = '0;  read_reg2 = '0;

        //          rst stl rw m2r wr  alu           mem           rr1 rr2 ewr ewdata       ewe rd1           rd2
        vecs.push_back(mk(0, 0, 1, 0, 5'd5,  32'h0000_1111, 32'h0,        5'd5,  5'd0,  5'd0,  32'h0,        0, 32'h0,        32'h0));
        // Write reg 5 via ALU: latched at N with bypass, array at N+1
        vecs.push_back(mk(1, 0, 1, 0, 5'd5,  32'h0000_1234, 32'h0000_0777, 5'd5,  5'd5,  5'd5,  32'h0000_1234, 1, 32'h0000_1234, 32'h0000_1234));
        vecs.push_back(mk(1, 0, 0, 0, 5'd5,  32'h0000_9999, 32'h0,        5'd5,  5'd0,  5'd5,  32'h0000_9999, 0, 32'h0000_1234, 32'h0));
        // Writes to reg 0 are dropped and never bypassed
        vecs.push_back(mk(1, 0, 1, 0, 5'd0,  32'h0000_FFFF, 32'h0,        5'd0,  5'd5,  5'd0,  32'h0000_FFFF, 1, 32'h0,        32'h0000_1234));
        vecs.push_back(mk(1, 0, 0, 0, 5'd0,  32'h0,        32'h0,        5'd0,  5'd0,  5'd0,  32'h0,        0, 32'h0,        32'h0));
        // MemtoReg=1 selects load data
        vecs.push_back(mk(1, 0, 1, 1, 5'd9,  32'h0000_BEEF, 32'h0000_CAFE, 5'd9,  5'd9,  5'd9,  32'h0000_CAFE, 1, 32'h0000_CAFE, 32'h0000_CAFE));
        vecs.push_back(mk(1, 0, 0, 0, 5'd9,  32'h0000_0001, 32'h0000_0002, 5'd9,  5'd5,  5'd9,  32'h0000_0001, 0, 32'h0000_CAFE, 32'h0000_1234));
        // Stall holds the latch at 3/0x55 while MEM presents 4/0x66
        vecs.push_back(mk(1, 0, 1, 0, 5'd3,  32'h0000_0055, 32'h0,        5'd3,  5'd4,  5'd3,  32'h0000_0055, 1, 32'h0000_0055, 32'h0));
        for (int i = 0; i < 3; i++) begin
            vecs.push_back(mk(1, 1, 1, 0, 5'd4, 32'h0000_0066, 32'h0,     5'd3,  5'd4,  5'd3,  32'h0000_0055, 1, 32'h0000_0055, 32'h0));
        end
        vecs.push_back(mk(1, 0, 1, 0, 5'd4,  32'h0000_0066, 32'h0,        5'd3,  5'd4,  5'd4,  32'h0000_0066, 1, 32'h0000_0055, 32'h0000_0066));
        vecs.push_back(mk(1, 0, 0, 0, 5'd0,  32'h0,        32'h0,        5'd4,  5'd3,  5'd0,  32'h0,        0, 32'h0000_0066, 32'h0000_0055));
        // Reset right after latching reg 7 discards the pending write
        vecs.push_back(mk(1, 0, 1, 0, 5'd7,  32'h0000_00AA, 32'h0,        5'd7,  5'd7,  5'd7,  32'h0000_00AA, 1, 32'h0000_00AA, 32'h0000_00AA));
        vecs.push_back(mk(0, 0, 1, 0, 5'd8,  32'h0000_00BB, 32'h0,        5'd7,  5'd3,  5'd0,  32'h0,        0, 32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 5'd7,  32'h0,        32'h0,        5'd7,  5'd9,  5'd7,  32'h0,        0, 32'h0,        32'h0));
        // Full-width data to reg 31, then reset wins over stall
        vecs.push_back(mk(1, 0, 1, 0, 5'd31, 32'hDEAD_BEEF, 32'h0,        5'd31, 5'd31, 5'd31, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF));
        vecs.push_back(mk(0, 1, 1, 0, 5'd31, 32'h1234_5678, 32'h0,        5'd31, 5'd4,  5'd0,  32'h0,        0, 32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 5'd0,  32'h0,        32'h0,        5'd31, 5'd4,  5'd0,  32'h0,        0, 32'h0,        32'h0));

        apply(0, vecs[0]);

        // Sweep every index while reset is held: all must read zero
        for (int i = 0; i < 32; i++) begin
            read_reg1 = 5'(i);
            read_reg2 = 5'(31 - i);
            #1;
            chk($sformatf("reset_read1[%0d]", i), read_data1, 32'h0);
            chk($sformatf("reset_read2[%0d]", 31 - i), read_data2, 32'h0);
        end

        for (int i = 1; i < vecs.size(); i++) begin
            apply(i, vecs[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
